// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared constants for the instruction-fetch stage.
//               PCSrc encodings, the bubble instruction and the fetch FSM
//               state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // Next-PC source select
    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_JREG   = 2'b11;

    // Instruction presented to IF/ID while IF_Valid=0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Fetch FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // first cycle after reset release, no request
        REQ  = 2'd1,   // request outstanding at req_addr
        DROP = 2'd2,   // waiting out a request whose data will be discarded
        HOLD = 2'd3    // acked instruction parked while IF/ID is stalled
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_next_pc_mux.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_mux
// Description : Combinational redirect-target select and +4 adder.
//   i_pc_src        : PCSrc encoding (00 sequential, else redirect)
//   i_base_pc       : address whose successor is needed (mod 2^32)
//   i_branch_target : target for PCSrc=01
//   i_jump_target   : target for PCSrc=10
//   i_reg_target    : target for PCSrc=11
//   o_redirect      : 1 when PCSrc != 00
//   o_target        : selected redirect target (undefined use when sequential)
//   o_base_plus4    : i_base_pc + 4, wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_mux
    import fetch_unit_pkg::*;
(
    input  logic [1:0]  i_pc_src,
    input  logic [31:0] i_base_pc,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_jump_target,
    input  logic [31:0] i_reg_target,
    output logic        o_redirect,
    output logic [31:0] o_target,
    output logic [31:0] o_base_plus4
);

    assign o_redirect   = (i_pc_src != PCSRC_SEQ);
    assign o_base_plus4 = i_base_pc + 32'd4;

    always_comb begin
        o_target = o_base_plus4;
        case (i_pc_src)
            PCSRC_BRANCH: o_target = i_branch_target;
            PCSRC_JUMP:   o_target = i_jump_target;
            PCSRC_JREG:   o_target = i_reg_target;
            default:      o_target = o_base_plus4;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage feeding the IF/ID register. Owns the
//               PC, issues req/ack fetches to instruction memory and
//               presents a registered {PC, PC+4, instruction, valid} bundle.
//   Clk, Reset (async, active-low)
//   PCWrite      : 1 advance, 0 stall
//   PCSrc        : 00 seq, 01 branch, 10 jump, 11 register jump
//   BranchTarget / JumpTarget / RegTarget : redirect targets
//   imem_req/imem_addr/imem_ack/imem_rdata : instruction memory handshake
//   IF_PC/IF_PCPlus4/IF_Instruction/IF_Valid : registered IF/ID bundle
//   IF_Flush     : combinational, high in any redirect cycle
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PCWrite,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] RegTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PCPlus4,
    output logic [31:0] IF_Instruction,
    output logic        IF_Valid,
    output logic        IF_Flush
);
    import fetch_unit_pkg::*;

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_req_addr, w_req_addr_nxt;
    logic [31:0]  r_if_pc, w_if_pc_nxt;
    logic [31:0]  r_if_pc4, w_if_pc4_nxt;
    logic [31:0]  r_if_instr, w_if_instr_nxt;
    logic         r_if_valid, w_if_valid_nxt;
    logic [31:0]  r_hold_pc, w_hold_pc_nxt;
    logic [31:0]  r_hold_instr, w_hold_instr_nxt;

    logic         w_redirect;
    logic [31:0]  w_target;
    logic [31:0]  w_base;
    logic [31:0]  w_base_plus4;

    // In HOLD the successor of interest is that of the parked instruction;
    // everywhere else it is that of the current request.
    assign w_base = (r_state == HOLD) ? r_hold_pc : r_req_addr;

    next_pc_mux u_next_pc_mux (
        .i_pc_src        (PCSrc),
        .i_base_pc       (w_base),
        .i_branch_target (BranchTarget),
        .i_jump_target   (JumpTarget),
        .i_reg_target    (RegTarget),
        .o_redirect      (w_redirect),
        .o_target        (w_target),
        .o_base_plus4    (w_base_plus4)
    );

    assign imem_req       = (r_state == REQ) || (r_state == DROP);
    assign imem_addr      = r_req_addr;
    assign IF_Flush       = w_redirect;
    assign IF_PC          = r_if_pc;
    assign IF_PCPlus4     = r_if_pc4;
    assign IF_Instruction = r_if_instr;
    assign IF_Valid       = r_if_valid;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_if_pc      <= 32'h0;
            r_if_pc4     <= 32'h0;
            r_if_instr   <= NOP_INSTR;
            r_if_valid   <= 1'b0;
            r_hold_pc    <= 32'h0;
            r_hold_instr <= 32'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_req_addr   <= w_req_addr_nxt;
            r_if_pc      <= w_if_pc_nxt;
            r_if_pc4     <= w_if_pc4_nxt;
            r_if_instr   <= w_if_instr_nxt;
            r_if_valid   <= w_if_valid_nxt;
            r_hold_pc    <= w_hold_pc_nxt;
            r_hold_instr <= w_hold_instr_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_req_addr_nxt   = r_req_addr;
        w_if_pc_nxt      = r_if_pc;
        w_if_pc4_nxt     = r_if_pc4;
        w_if_instr_nxt   = r_if_instr;
        w_if_valid_nxt   = r_if_valid;
        w_hold_pc_nxt    = r_hold_pc;
        w_hold_instr_nxt = r_hold_instr;

        if (w_redirect) begin
            // Redirect overrides stall: bubble IF/ID and steer the PC.
            w_pc_nxt       = w_target;
            w_if_valid_nxt = 1'b0;
            w_if_instr_nxt = NOP_INSTR;
            case (r_state)
                REQ: begin
                    if (imem_ack) begin
                        w_req_addr_nxt = w_target;
                    end else begin
                        // Request must stay up at the old address until acked.
                        w_state_nxt = DROP;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        w_req_addr_nxt = w_target;
                        w_state_nxt    = REQ;
                    end
                end
                default: begin
                    // IDLE or HOLD: nothing in flight, go straight to target.
                    w_req_addr_nxt = w_target;
                    w_state_nxt    = REQ;
                end
            endcase
        end else begin
            case (r_state)
                IDLE: begin
                    w_req_addr_nxt = r_pc;
                    w_state_nxt    = REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        if (PCWrite) begin
                            w_if_pc_nxt    = r_req_addr;
                            w_if_pc4_nxt   = w_base_plus4;
                            w_if_instr_nxt = imem_rdata;
                            w_if_valid_nxt = 1'b1;
                            w_pc_nxt       = w_base_plus4;
                            w_req_addr_nxt = w_base_plus4;
                        end else begin
                            w_hold_pc_nxt    = r_req_addr;
                            w_hold_instr_nxt = imem_rdata;
                            w_state_nxt      = HOLD;
                        end
                    end else if (PCWrite) begin
                        w_if_valid_nxt = 1'b0;
                        w_if_instr_nxt = NOP_INSTR;
                    end
                end
                DROP: begin
                    w_if_valid_nxt = 1'b0;
                    w_if_instr_nxt = NOP_INSTR;
                    if (imem_ack) begin
                        w_req_addr_nxt = r_pc;
                        w_state_nxt    = REQ;
                    end
                end
                HOLD: begin
                    if (PCWrite) begin
                        w_if_pc_nxt    = r_hold_pc;
                        w_if_pc4_nxt   = w_base_plus4;
                        w_if_instr_nxt = r_hold_instr;
                        w_if_valid_nxt = 1'b1;
                        w_pc_nxt       = w_base_plus4;
                        w_req_addr_nxt = w_base_plus4;
                        w_state_nxt    = REQ;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A behavioural memory with
//               programmable wait states answers fetches; each scenario pushes
//               the PCs it expects IF/ID to receive and a negedge monitor pops
//               and compares every delivered instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        PCWrite = 1'b1;
    logic [1:0]  PCSrc = 2'b00;
    logic [31:0] BranchTarget = 32'h0;
    logic [31:0] JumpTarget = 32'h0;
    logic [31:0] RegTarget = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] IF_PC;
    logic [31:0] IF_PCPlus4;
    logic [31:0] IF_Instruction;
    logic        IF_Valid;
    logic        IF_Flush;

    int n_pass = 0;
    int n_total = 0;
    int mem_wait = 0;
    int mem_cnt = 0;
    logic [31:0] exp_q[$];

    logic        pcw_prev = 1'b0;
    logic        chk_addr = 1'b0;
    logic [31:0] held_addr = 32'h0;

    fetch_unit dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .PCWrite        (PCWrite),
        .PCSrc          (PCSrc),
        .BranchTarget   (BranchTarget),
        .JumpTarget     (JumpTarget),
        .RegTarget      (RegTarget),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .IF_PC          (IF_PC),
        .IF_PCPlus4     (IF_PCPlus4),
        .IF_Instruction (IF_Instruction),
        .IF_Valid       (IF_Valid),
        .IF_Flush       (IF_Flush)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    // Memory: acks after mem_wait cycles of continuous request.
    assign imem_ack   = imem_req && (mem_cnt >= mem_wait);
    assign imem_rdata = imem_ack ? mem_data(imem_addr) : 32'hDEAD_BEEF;

    always @(posedge Clk) begin
        if (!Reset || !imem_req || imem_ack) mem_cnt <= 0;
        else                                 mem_cnt <= mem_cnt + 1;
        pcw_prev  <= Reset && PCWrite && (PCSrc == 2'b00);
        chk_addr  <= Reset && imem_req && !imem_ack;
        held_addr <= imem_addr;
    end

    // Monitor: address stability while a request waits, and scoreboard pop
    // on every new delivery to IF/ID.
    always @(negedge Clk) begin
        logic [31:0] e;
        if (Reset === 1'b1 && chk_addr === 1'b1 && imem_req === 1'b1) begin
            n_total++;
            if (imem_addr !== held_addr)
                $display("FAIL addr_stable: imem_addr=%h required=%h", imem_addr, held_addr);
            else n_pass++;
        end
        if (Reset === 1'b1 && pcw_prev === 1'b1 && IF_Valid === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_delivery: IF_PC=%h IF_Instruction=%h required=none",
                         IF_PC, IF_Instruction);
            end else begin
                e = exp_q.pop_front();
                if (IF_PC !== e || IF_PCPlus4 !== e + 32'd4 || IF_Instruction !== mem_data(e))
                    $display("FAIL delivery: IF_PC=%h PC4=%h instr=%h required %h %h %h",
                             IF_PC, IF_PCPlus4, IF_Instruction, e, e + 32'd4, mem_data(e));
                else n_pass++;
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic restart(input int wait_cycles);
        Reset    = 1'b0;
        PCWrite  = 1'b1;
        PCSrc    = 2'b00;
        mem_wait = wait_cycles;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
    endtask

    task automatic check_drained(input string name);
        @(negedge Clk);
        #1;
        n_total++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drained: pending=%0d required=0", name, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        n_total++;
        if ({IF_PC, IF_PCPlus4, IF_Instruction} !== 96'h0)
            $display("FAIL reset_if: pc=%h pc4=%h instr=%h required 0 0 0", IF_PC, IF_PCPlus4, IF_Instruction);
        else n_pass++;
        n_total++;
        if (IF_Valid !== 1'b0 || imem_req !== 1'b0 || IF_Flush !== 1'b0)
            $display("FAIL reset_ctl: valid=%b req=%b flush=%b required 0 0 0", IF_Valid, imem_req, IF_Flush);
        else n_pass++;
    endtask

    task automatic test_zero_wait();
        logic [31:0] ea [6] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20};
        logic        ev [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
        restart(0);
        for (int c = 0; c < 6; c++) begin
            step();
            n_total++;
            if (imem_req !== 1'b1 || imem_addr !== ea[c] || IF_Valid !== ev[c])
                $display("FAIL zero_wait_c%0d: req=%b addr=%h valid=%b required 1 %h %b",
                         c + 1, imem_req, imem_addr, IF_Valid, ea[c], ev[c]);
            else n_pass++;
        end
        check_drained("zero_wait");
    endtask

    task automatic test_wait2();
        logic [31:0] ea [7] = '{32'd0, 32'd0, 32'd0, 32'd4, 32'd4, 32'd4, 32'd8};
        logic        ev [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd4);
        restart(2);
        for (int c = 0; c < 7; c++) begin
            step();
            n_total++;
            if (imem_addr !== ea[c] || IF_Valid !== ev[c])
                $display("FAIL wait2_c%0d: addr=%h valid=%b required %h %b",
                         c + 1, imem_addr, IF_Valid, ea[c], ev[c]);
            else n_pass++;
        end
        check_drained("wait2");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
        restart(0);
        repeat (3) step();
        PCWrite = 1'b0;                 // coincides with ack of 0x8
        for (int c = 0; c < 3; c++) begin
            step();
            n_total++;
            if (IF_PC !== 32'd4 || IF_Valid !== 1'b1 || imem_req !== 1'b0)
                $display("FAIL stall_hold%0d: pc=%h valid=%b req=%b required 00000004 1 0",
                         c, IF_PC, IF_Valid, imem_req);
            else n_pass++;
        end
        PCWrite = 1'b1;
        step();
        n_total++;
        if (IF_PC !== 32'd8 || imem_addr !== 32'd12 || imem_req !== 1'b1)
            $display("FAIL stall_release: pc=%h addr=%h req=%b required 00000008 0000000c 1",
                     IF_PC, imem_addr, imem_req);
        else n_pass++;
        step();
        check_drained("stall");
    endtask

    task automatic test_branch_flush();
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
        exp_q.push_back(32'h100);
        restart(0);
        repeat (5) step();              // request to 0x10 now outstanding
        mem_wait     = 2;
        PCSrc        = 2'b01;
        BranchTarget = 32'h100;
        #1;
        n_total++;
        if (IF_Flush !== 1'b1 || imem_addr !== 32'h10)
            $display("FAIL branch_flush: flush=%b addr=%h required 1 00000010", IF_Flush, imem_addr);
        else n_pass++;
        step();
        PCSrc = 2'b00;
        #1;
        n_total++;
        if (IF_Flush !== 1'b0 || IF_Valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10)
            $display("FAIL branch_drop: flush=%b valid=%b req=%b addr=%h required 0 0 1 00000010",
                     IF_Flush, IF_Valid, imem_req, imem_addr);
        else n_pass++;
        step();
        step();
        n_total++;
        if (imem_addr !== 32'h100 || IF_Valid !== 1'b0)
            $display("FAIL branch_target_req: addr=%h valid=%b required 00000100 0", imem_addr, IF_Valid);
        else n_pass++;
        repeat (3) step();
        n_total++;
        if (IF_PC !== 32'h100 || IF_Valid !== 1'b1)
            $display("FAIL branch_target_out: pc=%h valid=%b required 00000100 1", IF_PC, IF_Valid);
        else n_pass++;
        check_drained("branch");
    endtask

    task automatic test_jreg_hold_wrap();
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd4);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        restart(0);
        repeat (3) step();
        PCWrite = 1'b0;
        step();                         // now in HOLD with 0x8 parked
        PCSrc     = 2'b11;
        RegTarget = 32'hFFFF_FFFC;
        #1;
        n_total++;
        if (IF_Flush !== 1'b1 || imem_req !== 1'b0)
            $display("FAIL jreg_flush: flush=%b req=%b required 1 0", IF_Flush, imem_req);
        else n_pass++;
        step();
        PCSrc   = 2'b00;
        PCWrite = 1'b1;
        #1;
        n_total++;
        if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1 || IF_Valid !== 1'b0)
            $display("FAIL jreg_req: addr=%h req=%b valid=%b required fffffffc 1 0",
                     imem_addr, imem_req, IF_Valid);
        else n_pass++;
        step();
        n_total++;
        if (IF_PCPlus4 !== 32'h0 || imem_addr !== 32'h0)
            $display("FAIL wrap: pc4=%h addr=%h required 00000000 00000000", IF_PCPlus4, imem_addr);
        else n_pass++;
        step();
        check_drained("jreg");
    endtask

    task automatic test_reset_mid_drop();
        exp_q.push_back(32'd0);
        restart(0);
        repeat (2) step();
        mem_wait   = 3;
        PCSrc      = 2'b10;
        JumpTarget = 32'h200;
        step();                         // now in DROP on 0x4
        PCSrc = 2'b00;
        #1;
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd4 || IF_Valid !== 1'b0)
            $display("FAIL drop_state: req=%b addr=%h valid=%b required 1 00000004 0",
                     imem_req, imem_addr, IF_Valid);
        else n_pass++;
        #1;
        Reset = 1'b0;                   // mid-cycle, asynchronous
        #1;
        n_total++;
        if (imem_req !== 1'b0 || IF_Valid !== 1'b0 || {IF_PC, IF_PCPlus4, IF_Instruction} !== 96'h0)
            $display("FAIL async_reset: req=%b valid=%b pc=%h pc4=%h instr=%h required 0 0 0 0 0",
                     imem_req, IF_Valid, IF_PC, IF_PCPlus4, IF_Instruction);
        else n_pass++;
        check_drained("drop");
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd4);
        restart(0);
        step();
        n_total++;
        if (imem_addr !== 32'd0 || imem_req !== 1'b1)
            $display("FAIL restart_addr: addr=%h req=%b required 00000000 1", imem_addr, imem_req);
        else n_pass++;
        repeat (2) step();
        check_drained("restart");
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait2();
        test_stall();
        test_branch_flush();
        test_jreg_hold_wrap();
        test_reset_mid_drop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
